// File: rtl/insn_decode_stage_if.sv
// ---------------------------------------------------------------------------
// insn_decode_stage_if
// Bundles every handshake and data signal around the decode stage: the fetch
// side (in_valid/in_ready/insn), the execute side (out_valid/out_ready and the
// registered decoded fields), the writeback return path, the flush request and
// the per-register reservation vector.
//   master : driven by the surroundings (fetch, execute, writeback)
//   slave  : the decode stage itself
// ---------------------------------------------------------------------------
interface insn_decode_stage_if #(
    parameter int LEN_INSN    = 32,
    parameter int LEN_OPECODE = 7,
    parameter int LEN_IMMF    = 1,
    parameter int LEN_REGNO   = 4,
    parameter int LEN_CC      = 4,
    parameter int LEN_IMM_EX  = 32,
    parameter int LEN_REG     = 32
);
    // Fetch handshake
    logic                      in_valid;
    logic                      in_ready;
    logic [LEN_INSN-1:0]       insn;

    // Execute handshake and decoded, registered fields
    logic                      out_valid;
    logic                      out_ready;
    logic [LEN_OPECODE-1:0]    opecode_o;
    logic [LEN_IMMF-1:0]       immf_o;
    logic [LEN_REGNO-1:0]      rd_o;
    logic [LEN_REGNO-1:0]      rs_o;
    logic [LEN_CC-1:0]         cc_o;
    logic [LEN_IMM_EX-1:0]     imm_o;
    logic [LEN_REG-1:0]        data_rd;
    logic [LEN_REG-1:0]        data_rs;
    logic                      wr_o;

    // Writeback return path from execute
    logic                      wb_i;
    logic [LEN_REGNO-1:0]      wb_r_i;
    logic [LEN_REG-1:0]        result_i;

    // Pipeline control and reservation status
    logic                      flush_i;
    logic [(2**LEN_REGNO)-1:0] busy_o;

    modport master (
        output in_valid, insn, out_ready, wb_i, wb_r_i, result_i, flush_i,
        input  in_ready, out_valid, opecode_o, immf_o, rd_o, rs_o, cc_o,
               imm_o, data_rd, data_rs, wr_o, busy_o
    );

    modport slave (
        input  in_valid, insn, out_ready, wb_i, wb_r_i, result_i, flush_i,
        output in_ready, out_valid, opecode_o, immf_o, rd_o, rs_o, cc_o,
               imm_o, data_rd, data_rs, wr_o, busy_o
    );
endinterface

// File: rtl/insn_decode_stage.sv
// ---------------------------------------------------------------------------
// insn_decode_stage
// Registered, back-pressured decode stage between fetch and execute. Splits
// the instruction into opecode/immf/rd/rs/cc, extends the immediate according
// to the opecode class, reads both operands from an internal register file
// (with writeback bypass) and keeps a reservation bit per register so that
// RAW/WAW hazards stall at decode.
// Ports:
//   clk  : single clock, all state updates on the rising edge
//   rst  : synchronous active-low reset
//   bus  : insn_decode_stage_if.slave carrying fetch/execute handshakes,
//          decoded outputs, writeback port, flush and busy vector
// ---------------------------------------------------------------------------
module insn_decode_stage #(
    parameter int LEN_INSN      = 32,
    parameter int LEN_OPECODE   = 7,
    parameter int LEN_IMMF      = 1,
    parameter int LEN_REGNO     = 4,
    parameter int LEN_CC        = 4,
    parameter int LEN_IMM       = 16,
    parameter int LEN_IMM_EX    = 32,
    parameter int LEN_REG       = 32,
    parameter int SHIFT_OPECODE = 25,
    parameter int SHIFT_IMMF    = 24,
    parameter int SHIFT_RD      = 20,
    parameter int SHIFT_RS      = 16,
    parameter int SHIFT_CC      = 0,
    parameter int SHIFT_IMM     = 0
) (
    input logic                clk,
    input logic                rst,
    insn_decode_stage_if.slave bus
);
    localparam int NREG = 2**LEN_REGNO;

    // Field extraction from the incoming instruction; fields may overlap.
    logic [LEN_OPECODE-1:0] w_opecode;
    logic [LEN_IMMF-1:0]    w_immf;
    logic [LEN_REGNO-1:0]   w_rd;
    logic [LEN_REGNO-1:0]   w_rs;
    logic [LEN_CC-1:0]      w_cc;
    logic [LEN_IMM-1:0]     w_immRaw;
    logic [3:0]             w_top4;
    logic                   w_wr;
    logic                   w_immfZero;

    assign w_opecode  = bus.insn[SHIFT_OPECODE +: LEN_OPECODE];
    assign w_immf     = bus.insn[SHIFT_IMMF +: LEN_IMMF];
    assign w_rd       = bus.insn[SHIFT_RD +: LEN_REGNO];
    assign w_rs       = bus.insn[SHIFT_RS +: LEN_REGNO];
    assign w_cc       = bus.insn[SHIFT_CC +: LEN_CC];
    assign w_immRaw   = bus.insn[SHIFT_IMM +: LEN_IMM];
    assign w_top4     = w_opecode[LEN_OPECODE-1 -: 4];
    assign w_immfZero = (w_immf == '0);
    // Only the 111x class leaves rd untouched.
    assign w_wr       = (w_opecode[LEN_OPECODE-1 -: 3] != 3'b111);

    // State
    logic [LEN_REG-1:0]     r_regs [NREG];
    logic [NREG-1:0]        r_busy;
    logic                   r_outValid;
    logic [LEN_OPECODE-1:0] r_opecode;
    logic [LEN_IMMF-1:0]    r_immf;
    logic [LEN_REGNO-1:0]   r_rd;
    logic [LEN_REGNO-1:0]   r_rs;
    logic [LEN_CC-1:0]      r_cc;
    logic [LEN_IMM_EX-1:0]  r_imm;
    logic [LEN_REG-1:0]     r_dataRd;
    logic [LEN_REG-1:0]     r_dataRs;
    logic                   r_wr;

    // Immediate extension: 0000 and 0011 sign-extend, 0001 takes only the
    // low five bits, everything else zero-extends. No immediate when immf=0.
    logic [LEN_IMM_EX-1:0] w_immEx;

    always_comb begin
        w_immEx = '0;
        if (!w_immfZero) begin
            case (w_top4)
                4'b0000, 4'b0011: w_immEx = LEN_IMM_EX'($signed(w_immRaw));
                4'b0001:          w_immEx = LEN_IMM_EX'(w_immRaw[4:0]);
                default:          w_immEx = LEN_IMM_EX'(w_immRaw);
            endcase
        end
    end

    // A register being written back this cycle is already released, both for
    // hazard detection and for the operand value (bypass).
    logic [NREG-1:0]    w_wbMask;
    logic [NREG-1:0]    w_busyEff;
    logic               w_hazard;
    logic               w_inReady;
    logic               w_accept;
    logic [LEN_REG-1:0] w_dataRd;
    logic [LEN_REG-1:0] w_dataRs;

    assign w_wbMask  = bus.wb_i ? (NREG'(1) << bus.wb_r_i) : '0;
    assign w_busyEff = r_busy & ~w_wbMask;
    assign w_hazard  = w_busyEff[w_rd] || (w_immfZero && w_busyEff[w_rs]);
    assign w_inReady = rst && !w_hazard && (!r_outValid || bus.out_ready)
                       && !bus.flush_i;
    assign w_accept  = bus.in_valid && w_inReady;

    assign w_dataRd = (bus.wb_i && (bus.wb_r_i == w_rd)) ? bus.result_i
                                                          : r_regs[w_rd];
    // rs is not an operand for immediate forms, so nothing is read for it.
    assign w_dataRs = !w_immfZero ? '0 :
                      ((bus.wb_i && (bus.wb_r_i == w_rs)) ? bus.result_i
                                                          : r_regs[w_rs]);

    // Reservation update: writeback and flush release first, then a new
    // accepting writer reserves, so a same-cycle set beats a clear.
    // A flush only releases rd when an instruction is actually held.
    logic [NREG-1:0] w_busyNext;

    always_comb begin
        w_busyNext = r_busy & ~w_wbMask;
        if (bus.flush_i && r_outValid && r_wr) begin
            w_busyNext[r_rd] = 1'b0;
        end
        if (w_accept && w_wr) begin
            w_busyNext[w_rd] = 1'b1;
        end
    end

    // Output register and handshake state. Decoded fields only change on an
    // accept, which keeps them stable while execute applies back-pressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_outValid <= 1'b0;
            r_opecode  <= '0;
            r_immf     <= '0;
            r_rd       <= '0;
            r_rs       <= '0;
            r_cc       <= '0;
            r_imm      <= '0;
            r_dataRd   <= '0;
            r_dataRs   <= '0;
            r_wr       <= 1'b0;
            r_busy     <= '0;
        end else begin
            r_busy <= w_busyNext;
            if (bus.flush_i) begin
                r_outValid <= 1'b0;
            end else if (w_accept) begin
                r_outValid <= 1'b1;
            end else if (bus.out_ready) begin
                r_outValid <= 1'b0;
            end
            if (w_accept) begin
                r_opecode <= w_opecode;
                r_immf    <= w_immf;
                r_rd      <= w_rd;
                r_rs      <= w_rs;
                r_cc      <= w_cc;
                r_imm     <= w_immEx;
                r_dataRd  <= w_dataRd;
                r_dataRs  <= w_dataRs;
                r_wr      <= w_wr;
            end
        end
    end

    // General register file, written only by the writeback port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.wb_i) begin
            r_regs[bus.wb_r_i] <= bus.result_i;
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.opecode_o = r_opecode;
    assign bus.immf_o    = r_immf;
    assign bus.rd_o      = r_rd;
    assign bus.rs_o      = r_rs;
    assign bus.cc_o      = r_cc;
    assign bus.imm_o     = r_imm;
    assign bus.data_rd   = r_dataRd;
    assign bus.data_rs   = r_dataRs;
    assign bus.wr_o      = r_wr;
    assign bus.busy_o    = r_busy;
endmodule

// File: tb/tb_insn_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_insn_decode_stage
// Directed bench for insn_decode_stage. Issued instructions push their
// hand-computed decode result into a queue; a monitor pops and compares on
// every execute-side transfer. Stall, freeze, flush and reservation behaviour
// is checked directly from the stimulus process.
// ---------------------------------------------------------------------------
module tb_insn_decode_stage;
    logic clk;
    logic rst;

    insn_decode_stage_if bus ();

    insn_decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [6:0]  op;
        logic        immf;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  cc;
        logic [31:0] imm;
        logic [31:0] dRd;
        logic [31:0] dRs;
        logic        wr;
        bit          chkRs;
    } exp_t;

    exp_t sb[$];
    int   checkCount = 0;
    int   errorCount = 0;
    int   waits;

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mkInsn(logic [6:0] op, logic immf,
                                           logic [3:0] rd, logic [3:0] rs,
                                           logic [15:0] imm16);
        return {op, immf, rd, rs, imm16};
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents one instruction until it is accepted (bounded), pushing its
    // expected decode into the scoreboard at the accepting edge.
    task automatic applyStimulus(logic [6:0] op, logic immf, logic [3:0] rd,
                                 logic [3:0] rs, logic [15:0] imm16,
                                 logic [31:0] immEx, logic [31:0] dRd,
                                 logic [31:0] dRs, logic wr, bit doPush,
                                 output int waitCycles);
        exp_t e;
        bit   accepted;
        e.op = op; e.immf = immf; e.rd = rd; e.rs = rs; e.cc = imm16[3:0];
        e.imm = immEx; e.dRd = dRd; e.dRs = dRs; e.wr = wr;
        e.chkRs = (immf == 1'b0);
        accepted   = 0;
        waitCycles = 0;
        bus.insn     = mkInsn(op, immf, rd, rs, imm16);
        bus.in_valid = 1'b1;
        while (!accepted && waitCycles < 20) begin
            @(negedge clk);
            if (bus.in_ready) begin
                accepted = 1;
                if (doPush) sb.push_back(e);
            end else begin
                waitCycles++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL accept timeout: insn 0x%08h not accepted, expected accept", bus.insn);
        end
    endtask

    task automatic doWriteback(logic [3:0] r, logic [31:0] val);
        bus.wb_i     = 1'b1;
        bus.wb_r_i   = r;
        bus.result_i = val;
        @(posedge clk); #1;
        bus.wb_i = 1'b0;
    endtask

    // Monitor: every execute-side transfer must match the queue head.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL unexpected output: opecode 0x%02h with empty scoreboard", bus.opecode_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("opecode_o", 32'(bus.opecode_o), 32'(e.op));
                checkOutput("immf_o",    32'(bus.immf_o),    32'(e.immf));
                checkOutput("rd_o",      32'(bus.rd_o),      32'(e.rd));
                checkOutput("rs_o",      32'(bus.rs_o),      32'(e.rs));
                checkOutput("cc_o",      32'(bus.cc_o),      32'(e.cc));
                checkOutput("imm_o",     bus.imm_o,          e.imm);
                checkOutput("data_rd",   bus.data_rd,        e.dRd);
                if (e.chkRs) checkOutput("data_rs", bus.data_rs, e.dRs);
                checkOutput("wr_o",      32'(bus.wr_o),      32'(e.wr));
            end
        end
    end

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.insn     = mkInsn(7'b0000001, 1'b1, 4'd1, 4'd0, 16'hFFF0);
        bus.out_ready = 1'b1;
        bus.wb_i     = 1'b0;
        bus.wb_r_i   = '0;
        bus.result_i = '0;
        bus.flush_i  = 1'b0;

        // Reset held for two cycles while fetch offers an instruction
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset in_ready",  32'(bus.in_ready),  32'd0);
            checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
            checkOutput("reset busy_o",    32'(bus.busy_o),    32'd0);
            checkOutput("reset imm_o",     bus.imm_o,          32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("post-reset in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // Immediate classes, back to back, distinct destinations
        $display("[TB] immediate classes");
        applyStimulus(7'b0000001, 1'b1, 4'd1, 4'd0, 16'hFFF0, 32'hFFFFFFF0, 32'h0, 32'h0, 1'b1, 1, waits);
        applyStimulus(7'b0001000, 1'b1, 4'd2, 4'd0, 16'hFFF3, 32'h00000013, 32'h0, 32'h0, 1'b1, 1, waits);
        applyStimulus(7'b0011000, 1'b1, 4'd4, 4'd0, 16'h8000, 32'hFFFF8000, 32'h0, 32'h0, 1'b1, 1, waits);
        applyStimulus(7'b0100000, 1'b1, 4'd6, 4'd0, 16'h8000, 32'h00008000, 32'h0, 32'h0, 1'b1, 1, waits);
        applyStimulus(7'b0000001, 1'b0, 4'd8, 4'd9, 16'hFFF0, 32'h00000000, 32'h0, 32'h0, 1'b1, 1, waits);
        @(negedge clk);
        checkOutput("busy after writers", 32'(bus.busy_o), 32'h0000_0156);
        @(posedge clk); #1;

        // Release reservations and load register values
        doWriteback(4'd1, 32'h11111111);
        doWriteback(4'd2, 32'h22222222);
        doWriteback(4'd4, 32'h44444444);
        doWriteback(4'd6, 32'h66666666);
        doWriteback(4'd8, 32'h88888888);
        @(negedge clk);
        checkOutput("busy after writebacks", 32'(bus.busy_o), 32'h0);
        @(posedge clk); #1;

        // RAW: writer rd=3, then reader of rs=3 stalls until writeback
        $display("[TB] RAW stall");
        applyStimulus(7'b0000000, 1'b1, 4'd3, 4'd0, 16'h0005, 32'h00000005, 32'h0, 32'h0, 1'b1, 1, waits);
        bus.insn     = mkInsn(7'b1110000, 1'b0, 4'd1, 4'd3, 16'h0000);
        bus.in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("RAW stall in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.wb_i     = 1'b1;
        bus.wb_r_i   = 4'd3;
        bus.result_i = 32'hDEADBEEF;
        @(negedge clk);
        checkOutput("RAW release in_ready", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) begin
            sb.push_back('{op: 7'b1110000, immf: 1'b0, rd: 4'd1, rs: 4'd3, cc: 4'd0,
                           imm: 32'h0, dRd: 32'h11111111, dRs: 32'hDEADBEEF,
                           wr: 1'b0, chkRs: 1'b1});
        end
        @(posedge clk); #1;
        bus.wb_i     = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("busy after RAW", 32'(bus.busy_o), 32'h0);
        @(posedge clk); #1;

        // Back-pressure: A held for three cycles with B waiting
        $display("[TB] back-pressure");
        bus.out_ready = 1'b0;
        applyStimulus(7'b1110001, 1'b1, 4'd5, 4'd0, 16'h0007, 32'h00000007, 32'h0, 32'h0, 1'b0, 1, waits);
        bus.insn     = mkInsn(7'b1111111, 1'b1, 4'd2, 4'd0, 16'h1234);
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("backpressure in_ready",  32'(bus.in_ready),  32'd0);
            checkOutput("backpressure out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("frozen opecode_o",       32'(bus.opecode_o), 32'h71);
            checkOutput("frozen imm_o",           bus.imm_o,          32'h7);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        applyStimulus(7'b1111111, 1'b1, 4'd2, 4'd0, 16'h1234, 32'h00001234, 32'h22222222, 32'h0, 1'b0, 1, waits);
        checkOutput("throughput B stalls", 32'(waits), 32'd0);
        applyStimulus(7'b1110010, 1'b0, 4'd4, 4'd6, 16'hABCD, 32'h00000000, 32'h44444444, 32'h66666666, 1'b0, 1, waits);
        checkOutput("throughput C stalls", 32'(waits), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;

        // Flush a held writer rd=5
        $display("[TB] flush");
        bus.out_ready = 1'b0;
        applyStimulus(7'b0000000, 1'b1, 4'd5, 4'd0, 16'h0001, 32'h00000001, 32'h0, 32'h0, 1'b1, 0, waits);
        @(negedge clk);
        checkOutput("pre-flush out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("pre-flush busy[5]",   32'(bus.busy_o[5]), 32'd1);
        @(posedge clk); #1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        checkOutput("flush in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.flush_i   = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post-flush out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("post-flush busy[5]",   32'(bus.busy_o[5]), 32'd0);
        @(posedge clk); #1;

        // Same-cycle writeback r=7 and accept of writer rd=7
        $display("[TB] set/clear collision");
        bus.wb_i     = 1'b1;
        bus.wb_r_i   = 4'd7;
        bus.result_i = 32'h77777777;
        applyStimulus(7'b0100001, 1'b1, 4'd7, 4'd0, 16'h0002, 32'h00000002, 32'h77777777, 32'h0, 1'b1, 1, waits);
        bus.wb_i = 1'b0;
        @(negedge clk);
        checkOutput("collision busy_o", 32'(bus.busy_o), 32'h0000_0080);
        @(posedge clk); #1;
        doWriteback(4'd7, 32'h12345678);
        @(negedge clk);
        checkOutput("final busy_o", 32'(bus.busy_o), 32'h0);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
